awg_channel_bank: RTL and testbench
===================================

Name: awg_channel_bank

Overview:
- Parametrised multi-channel direct-digital-synthesis waveform core. Successor to the single-channel waveform generator.
- Each channel has its own phase accumulator, waveform type, frequency word, amplitude and DC offset.
- Configuration is written through a valid/ready register port into shadow registers. Commits are applied glitch-free at each channel's phase wrap.
- Sits between the UART control logic and the DAC output pins.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
PHASE_W, 16, phase accumulator / frequency word width
OUT_W, 10, sample width per channel
AMP_W, 10, amplitude word width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when valid&ready
cfg_ch  in  3  target channel index
cfg_addr  in  2  0=type, 1=freq, 2=amplitude, 3=offset
cfg_data  in  PHASE_W  write data, LSB-aligned, truncated to field width
commit  in  NUM_CH  per-channel commit strobe (1-cycle pulse)
sync_in  in  1  phase-reset pulse for all channels
pending  out  NUM_CH  commit awaiting phase wrap, per channel
wrap  out  NUM_CH  1-cycle pulse on accumulator carry-out, per channel
sample_out  out  NUM_CH*OUT_W  channel k at bits [k*OUT_W +: OUT_W]

Behaviour:
- Reset: all shadow/active regs 0 (type 0 = square, freq 0, amp 0, offset 0). Accumulators 0. pending=0, wrap=0, sample_out=0, cfg_ready=1.
- Write handshake:
  - A write occurs on clk when cfg_valid&cfg_ready. It updates shadow[cfg_ch][cfg_addr] only.
  - cfg_ready = !pending[cfg_ch] && cfg_ch<NUM_CH, combinational from registers.
  - Writes to cfg_ch>=NUM_CH stall forever (ready=0).
- Commit:
  - commit[k] sets pending[k].
  - Shadow-to-active copy happens on the cycle wrap[k] is generated, or on the next clock if active freq[k]==0. pending[k] clears in the same cycle as the copy.
  - A commit while already pending is a no-op.
  - A write and a commit to the same channel in the same cycle: the write lands in shadow first, so the commit includes it.
- Accumulator: acc[k] <= acc[k] + freq_active[k] each cycle. wrap[k] = carry-out of that add, registered.
- sync_in:
  - All acc <= 0 next cycle, and wrap is forced 0 that cycle.
  - Pending commits are applied on that same cycle, treated as a wrap.
  - sync_in has priority over normal accumulation.
- Shaping, with p = acc:
  - Square: MSB ? 2^OUT_W-1 : 0.
  - Sawtooth (type 1): p[PHASE_W-1 -: OUT_W].
  - Triangle (type 2): MSB ? ~p[PHASE_W-2 -: OUT_W] : p[PHASE_W-2 -: OUT_W].
  - DC (type 3): raw=0.
- Scale: (raw*amp) >> AMP_W, kept to OUT_W bits, unsigned.
- Offset: scaled+offset, saturating at 2^OUT_W-1; no wrap-around.
- Pipeline: stage 1 raw, stage 2 scaled, stage 3 sample_out.
  - sample_out at cycle t+3 is computed from the acc value registered at t.
  - The type/amp/offset used for that sample are the values active at t, pipelined alongside the data. A commit never mixes settings within one sample.
- Reset mid-operation: rst wins over all inputs. Pending commits are discarded and the pipeline is flushed to 0.

Decomposition:
- Package awg_pkg holds:
  - waveform type enum (WF_SQUARE, WF_SAW, WF_TRI, WF_DC)
  - cfg address constants (CFG_TYPE, CFG_FREQ, CFG_AMP, CFG_OFFSET)
  - default widths
- One sub-module awg_channel, instantiated NUM_CH times with generate. It contains:
  - shadow/active regs
  - pending logic
  - accumulator
  - the 3-stage pipeline
- The bank top does cfg decode, cfg_ready muxing and output packing.

Test Plan:
- Reset then idle: all sample_out=0, pending=0, wrap=0, cfg_ready=1 for ≥20 cycles.
- Ch0 saw:
  - Stimulus: write type=1, freq=0x1000, amp=1023, offset=0, commit[0].
  - pending[0] clears the next cycle (freq active was 0).
  - sample_out[9:0] sequence 0,63,127,191,… starting 3 cycles after the copy.
  - wrap[0] pulses every 16 cycles.
- Ch1 square:
  - Stimulus: type=0, freq=0x8000, amp=1023, offset=512.
  - Output alternates 1023 (saturated from 1534) and 512 each cycle.
  - Ch0 is unaffected.
- Glitch-free commit:
  - Setup: ch0 running with freq=0x1000; write amp=512, commit[0].
  - cfg_ready for ch0 is 0 until wrap.
  - The amplitude change appears exactly 3 cycles after the wrap pulse, never mid-ramp.
- sync_in with ch0 at 0x0800 and ch1 mid-ramp: both accumulators read 0 next cycle, no wrap pulse, and a pending commit is applied in that cycle.
- Boundaries:
  - cfg_ch=NUM_CH gives cfg_ready=0.
  - Triangle type=2, freq=0x0400: output rises 0→1022, then falls symmetrically.
  - DC type=3, offset=300 gives a constant 300.
  - Reset asserted mid-ramp gives all zeros the next cycle.

Source files
------------

// File: rtl/awg_pkg.sv
// Shared types and default widths for the multi-channel DDS waveform bank.
package awg_pkg;

   localparam int unsigned DEF_NUM_CH  = 2;
   localparam int unsigned DEF_PHASE_W = 16;
   localparam int unsigned DEF_OUT_W   = 10;
   localparam int unsigned DEF_AMP_W   = 10;
   localparam int unsigned CH_IDX_W    = 3;
   localparam int unsigned CFG_ADDR_W  = 2;

   typedef enum logic [1:0] {
      WF_SQUARE = 2'd0,
      WF_SAW    = 2'd1,
      WF_TRI    = 2'd2,
      WF_DC     = 2'd3
   } wf_type_e;

   localparam logic [CFG_ADDR_W-1:0] CFG_TYPE   = 2'd0;
   localparam logic [CFG_ADDR_W-1:0] CFG_FREQ   = 2'd1;
   localparam logic [CFG_ADDR_W-1:0] CFG_AMP    = 2'd2;
   localparam logic [CFG_ADDR_W-1:0] CFG_OFFSET = 2'd3;

endpackage

// File: rtl/awg_channel_bank_if.sv
// Configuration register-write port (valid/ready) of the waveform bank.
interface awg_channel_bank_if
   import awg_pkg::*;
#(
   parameter int unsigned PHASE_W = DEF_PHASE_W
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [CH_IDX_W-1:0]   cfg_ch;
   logic [CFG_ADDR_W-1:0] cfg_addr;
   logic [PHASE_W-1:0]    cfg_data;

   modport master (output cfg_valid, cfg_ch, cfg_addr, cfg_data, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/awg_channel.sv
// One DDS channel: shadow/active settings, wrap-aligned commit, phase
// accumulator and a 3-stage shape/scale/offset pipeline.
module awg_channel
   import awg_pkg::*;
#(
   parameter int unsigned PHASE_W = DEF_PHASE_W,
   parameter int unsigned OUT_W   = DEF_OUT_W,
   parameter int unsigned AMP_W   = DEF_AMP_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wr_en,
   input  logic [CFG_ADDR_W-1:0] i_wr_addr,
   input  logic [PHASE_W-1:0]    i_wr_data,
   input  logic                  i_commit,
   input  logic                  i_sync,
   output logic                  o_pending,
   output logic                  o_wrap,
   output logic [OUT_W-1:0]      o_sample
);
   localparam int unsigned PROD_W = OUT_W + AMP_W;

   wf_type_e           r_sh_type, r_act_type;
   logic [PHASE_W-1:0] r_sh_freq, r_act_freq;
   logic [AMP_W-1:0]   r_sh_amp,  r_act_amp;
   logic [OUT_W-1:0]   r_sh_off,  r_act_off;
   logic               r_pending;
   logic [PHASE_W-1:0] r_acc;
   logic               r_wrap;
   logic [OUT_W-1:0]   r_s1_raw;
   logic [AMP_W-1:0]   r_s1_amp;
   logic [OUT_W-1:0]   r_s1_off;
   logic [OUT_W-1:0]   r_s2_scaled;
   logic [OUT_W-1:0]   r_s2_off;
   logic [OUT_W-1:0]   r_sample;

   logic [PHASE_W:0]   w_sum;
   logic               w_copy;
   logic [OUT_W-1:0]   w_raw;
   logic [PROD_W-1:0]  w_prod;
   logic [OUT_W-1:0]   w_scaled;
   logic [OUT_W:0]     w_off_sum;

   // Settings only change at a phase boundary (wrap/sync), or at once when stopped.
   assign w_sum  = {1'b0, r_acc} + {1'b0, r_act_freq};
   assign w_copy = r_pending && (i_sync || w_sum[PHASE_W] || (r_act_freq == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_type  <= WF_SQUARE;
         r_sh_freq  <= '0;
         r_sh_amp   <= '0;
         r_sh_off   <= '0;
         r_act_type <= WF_SQUARE;
         r_act_freq <= '0;
         r_act_amp  <= '0;
         r_act_off  <= '0;
         r_pending  <= 1'b0;
      end else begin
         if (i_wr_en) begin
            case (i_wr_addr)
               CFG_TYPE: r_sh_type <= wf_type_e'(i_wr_data[1:0]);
               CFG_FREQ: r_sh_freq <= i_wr_data;
               CFG_AMP:  r_sh_amp  <= AMP_W'(i_wr_data);
               default:  r_sh_off  <= OUT_W'(i_wr_data);
            endcase
         end
         if (w_copy) begin
            r_act_type <= r_sh_type;
            r_act_freq <= r_sh_freq;
            r_act_amp  <= r_sh_amp;
            r_act_off  <= r_sh_off;
            r_pending  <= 1'b0;
         end else if (i_commit) begin
            r_pending  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_sync) begin
         r_acc  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_acc  <= w_sum[PHASE_W-1:0];
         r_wrap <= w_sum[PHASE_W];
      end
   end

   always_comb begin
      w_raw = '0;
      case (r_act_type)
         WF_SQUARE: w_raw = {OUT_W{r_acc[PHASE_W-1]}};
         WF_SAW:    w_raw = r_acc[PHASE_W-1 -: OUT_W];
         WF_TRI:    w_raw = r_acc[PHASE_W-1] ? ~r_acc[PHASE_W-2 -: OUT_W]
                                             :  r_acc[PHASE_W-2 -: OUT_W];
         default:   w_raw = '0;
      endcase
   end

   assign w_prod    = PROD_W'(r_s1_raw) * PROD_W'(r_s1_amp);
   assign w_scaled  = OUT_W'(w_prod >> AMP_W);
   assign w_off_sum = (OUT_W+1)'(r_s2_scaled) + (OUT_W+1)'(r_s2_off);

   // amp/offset travel with the data so one sample never mixes two settings.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_raw    <= '0;
         r_s1_amp    <= '0;
         r_s1_off    <= '0;
         r_s2_scaled <= '0;
         r_s2_off    <= '0;
         r_sample    <= '0;
      end else begin
         r_s1_raw    <= w_raw;
         r_s1_amp    <= r_act_amp;
         r_s1_off    <= r_act_off;
         r_s2_scaled <= w_scaled;
         r_s2_off    <= r_s1_off;
         r_sample    <= w_off_sum[OUT_W] ? '1 : w_off_sum[OUT_W-1:0];
      end
   end

   assign o_pending = r_pending;
   assign o_wrap    = r_wrap;
   assign o_sample  = r_sample;

endmodule

// File: rtl/awg_channel_bank.sv
// Multi-channel DDS waveform bank: config decode, ready muxing and packing
// of per-channel samples toward the DAC pins.
module awg_channel_bank
   import awg_pkg::*;
#(
   parameter int unsigned NUM_CH  = DEF_NUM_CH,
   parameter int unsigned PHASE_W = DEF_PHASE_W,
   parameter int unsigned OUT_W   = DEF_OUT_W,
   parameter int unsigned AMP_W   = DEF_AMP_W
) (
   input  logic                    clk,
   input  logic                    rst,
   awg_channel_bank_if.slave       cfg_bus,
   input  logic [NUM_CH-1:0]       commit,
   input  logic                    sync_in,
   output logic [NUM_CH-1:0]       pending,
   output logic [NUM_CH-1:0]       wrap,
   output logic [NUM_CH*OUT_W-1:0] sample_out
);
   logic              w_ch_ok;
   logic              w_ch_pending;
   logic              w_accept;
   logic [NUM_CH-1:0] w_wr_en;

   // Unimplemented channel indices never match, so such writes stall.
   always_comb begin
      w_ch_ok      = 1'b0;
      w_ch_pending = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (cfg_bus.cfg_ch == CH_IDX_W'(k)) begin
            w_ch_ok      = 1'b1;
            w_ch_pending = pending[k];
         end
      end
   end

   assign cfg_bus.cfg_ready = w_ch_ok && !w_ch_pending;
   assign w_accept          = cfg_bus.cfg_valid && cfg_bus.cfg_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_wr_en[k] = w_accept && (cfg_bus.cfg_ch == CH_IDX_W'(k));

      awg_channel #(
         .PHASE_W (PHASE_W),
         .OUT_W   (OUT_W),
         .AMP_W   (AMP_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_wr_en   (w_wr_en[k]),
         .i_wr_addr (cfg_bus.cfg_addr),
         .i_wr_data (cfg_bus.cfg_data),
         .i_commit  (commit[k]),
         .i_sync    (sync_in),
         .o_pending (pending[k]),
         .o_wrap    (wrap[k]),
         .o_sample  (sample_out[k*OUT_W +: OUT_W])
      );
   end

endmodule

// File: tb/tb_awg_channel_bank.sv
// Directed bench for awg_channel_bank: table of waveform settings plus
// hand-written wrap/commit/sync/reset sequences.
module tb_awg_channel_bank;
   import awg_pkg::*;

   localparam int unsigned NUM_CH  = 2;
   localparam int unsigned PHASE_W = 16;
   localparam int unsigned OUT_W   = 10;
   localparam int unsigned AMP_W   = 10;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       commit;
   logic                    sync_in;
   logic [NUM_CH-1:0]       pending;
   logic [NUM_CH-1:0]       wrap;
   logic [NUM_CH*OUT_W-1:0] sample_out;

   awg_channel_bank_if #(.PHASE_W(PHASE_W)) bus ();

   awg_channel_bank #(
      .NUM_CH (NUM_CH), .PHASE_W (PHASE_W), .OUT_W (OUT_W), .AMP_W (AMP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_bus    (bus),
      .commit     (commit),
      .sync_in    (sync_in),
      .pending    (pending),
      .wrap       (wrap),
      .sample_out (sample_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wtype;
      logic [15:0] freq;
      logic [9:0]  amp;
      logic [9:0]  off;
      logic [9:0]  exp [6];
   } vec_t;

   vec_t vecs [7];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] smp(input int ch);
      return sample_out[ch*OUT_W +: OUT_W];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      commit = '0;
      sync_in = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_ch = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [1:0] addr,
                     input logic [15:0] data, input logic [NUM_CH-1:0] cm);
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = ch;
      bus.cfg_addr  = addr;
      bus.cfg_data  = data;
      commit        = cm;
      #1;
      chk("wr_ready", 32'(bus.cfg_ready), 32'd1);
      step();
      bus.cfg_valid = 1'b0;
      commit        = '0;
   endtask

   task automatic prog(input int ch, input logic [1:0] t, input logic [15:0] f,
                       input logic [9:0] a, input logic [9:0] o);
      logic [2:0] c;
      c = 3'(ch);
      wr(c, CFG_TYPE, 16'(t), '0);
      wr(c, CFG_FREQ, f, '0);
      wr(c, CFG_AMP, 16'(a), '0);
      wr(c, CFG_OFFSET, 16'(o), NUM_CH'(1) << ch);
   endtask

   task automatic wait_wrap(input int ch, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         step();
         if (wrap[ch]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;

      vecs[0] = '{2'd1, 16'h1000, 10'd1023, 10'd0,   '{10'd0, 10'd63, 10'd127, 10'd191, 10'd255, 10'd319}};
      vecs[1] = '{2'd0, 16'h8000, 10'd1023, 10'd512, '{10'd512, 10'd1023, 10'd512, 10'd1023, 10'd512, 10'd1023}};
      vecs[2] = '{2'd2, 16'h0400, 10'd1023, 10'd0,   '{10'd0, 10'd31, 10'd63, 10'd95, 10'd127, 10'd159}};
      vecs[3] = '{2'd3, 16'h1000, 10'd1023, 10'd300, '{10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd300}};
      vecs[4] = '{2'd1, 16'h1000, 10'd512,  10'd0,   '{10'd0, 10'd32, 10'd64, 10'd96, 10'd128, 10'd160}};
      vecs[5] = '{2'd1, 16'h2000, 10'd1023, 10'd900, '{10'd900, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023}};
      vecs[6] = '{2'd2, 16'h8000, 10'd1023, 10'd0,   '{10'd0, 10'd1022, 10'd0, 10'd1022, 10'd0, 10'd1022}};

      bus.cfg_addr = '0;
      bus.cfg_data = '0;

      // Reset then idle
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_sample", 32'(sample_out), 32'd0);
         chk("idle_pending", 32'(pending), 32'd0);
         chk("idle_wrap", 32'(wrap), 32'd0);
         chk("idle_ready", 32'(bus.cfg_ready), 32'd1);
      end

      // Table: program ch0 from reset, commit with the last write
      for (int i = 0; i < 7; i++) begin
         do_reset();
         prog(0, vecs[i].wtype, vecs[i].freq, vecs[i].amp, vecs[i].off);
         chk($sformatf("vec%0d_pending_set", i), 32'(pending[0]), 32'd1);
         step();
         chk($sformatf("vec%0d_pending_clr", i), 32'(pending[0]), 32'd0);
         step(); step(); step();
         for (int j = 0; j < 6; j++) begin
            chk($sformatf("vec%0d_s%0d", i, j), 32'(smp(0)), 32'(vecs[i].exp[j]));
            step();
         end
      end

      // Saw wrap period of 16 cycles
      do_reset();
      prog(0, 2'd1, 16'h1000, 10'd1023, 10'd0);
      wait_wrap(0, ok);
      chk("saw_wrap_found", 32'(ok), 32'd1);
      for (int j = 1; j <= 16; j++) begin
         step();
         chk($sformatf("saw_wrap_c%0d", j), 32'(wrap[0]), (j == 16) ? 32'd1 : 32'd0);
      end

      // Ch1 square alongside running ch0
      prog(1, 2'd0, 16'h8000, 10'd1023, 10'd512);
      step();
      chk("sq1_pending_clr", 32'(pending[1]), 32'd0);
      step(); step(); step();
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("sq1_s%0d", j), 32'(smp(1)), (j % 2 == 0) ? 32'd512 : 32'd1023);
         step();
      end
      wait_wrap(0, ok);
      chk("ch0_wrap_found", 32'(ok), 32'd1);
      step(); step(); step();
      chk("ch0_unaffected_a", 32'(smp(0)), 32'd0);
      step();
      chk("ch0_unaffected_b", 32'(smp(0)), 32'd63);

      // Glitch-free amplitude commit
      wait_wrap(0, ok);
      repeat (4) step();
      wr(3'd0, CFG_AMP, 16'd512, 2'b01);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (wrap[0]) begin
            ok = 1'b1;
            break;
         end
         chk("glitch_ready_low", 32'(bus.cfg_ready), 32'd0);
         chk("glitch_pending_high", 32'(pending[0]), 32'd1);
      end
      chk("glitch_wrap_found", 32'(ok), 32'd1);
      chk("glitch_pending_clr", 32'(pending[0]), 32'd0);
      chk("glitch_ready_back", 32'(bus.cfg_ready), 32'd1);
      step(); chk("glitch_old_amp_a", 32'(smp(0)), 32'd895);
      step(); chk("glitch_old_amp_b", 32'(smp(0)), 32'd959);
      step(); chk("glitch_wrap_pt", 32'(smp(0)), 32'd0);
      step(); chk("glitch_new_amp_a", 32'(smp(0)), 32'd32);
      step(); chk("glitch_new_amp_b", 32'(smp(0)), 32'd64);

      // sync_in with a pending commit
      do_reset();
      prog(0, 2'd1, 16'h0800, 10'd1023, 10'd0);
      prog(1, 2'd1, 16'h1000, 10'd1023, 10'd0);
      repeat (5) step();
      wr(3'd0, CFG_AMP, 16'd512, 2'b01);
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      chk("sync_pending_applied", 32'(pending), 32'd0);
      chk("sync_no_wrap", 32'(wrap), 32'd0);
      step(); step(); step();
      chk("sync_ch0_zero", 32'(smp(0)), 32'd0);
      chk("sync_ch1_zero", 32'(smp(1)), 32'd0);
      step();
      chk("sync_ch0_new_amp", 32'(smp(0)), 32'd16);
      chk("sync_ch1_next", 32'(smp(1)), 32'd63);

      // Out-of-range channel stalls
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 3'd2;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("bad_ch2_ready", 32'(bus.cfg_ready), 32'd0);
      end
      bus.cfg_ch = 3'd7;
      #1;
      chk("bad_ch7_ready", 32'(bus.cfg_ready), 32'd0);
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = 3'd1;
      #1;
      chk("ch1_ready_ok", 32'(bus.cfg_ready), 32'd1);

      // Reset mid-ramp discards a pending commit and flushes the pipeline
      step();
      wr(3'd0, CFG_AMP, 16'd100, 2'b01);
      chk("rst_pre_pending", 32'(pending[0]), 32'd1);
      rst     = 1'b1;
      commit  = '1;
      sync_in = 1'b1;
      step();
      chk("rst_sample", 32'(sample_out), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      rst     = 1'b0;
      commit  = '0;
      sync_in = 1'b0;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("post_rst_sample", 32'(sample_out), 32'd0);
         chk("post_rst_pending", 32'(pending), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
